// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: instruction handshake, status and datapath control bundle for control_unit_mc
interface control_unit_mc_if #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int INSTR_W = 32,
  parameter int ADDR_W = 9
);
  logic instr_valid;
  logic [INSTR_W-1:0] instr;
  logic instr_ready;
  logic [3:0] sreg;
  logic [OP_W-1:0] opcode;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic alu_start;
  logic hold;
  logic jump_en;
  logic [ADDR_W-1:0] pc;
  logic illegal;
  logic halted;
  modport master (
    output instr_valid, instr, sreg,
    input instr_ready, opcode, operand_a, operand_b, alu_start, hold, jump_en, pc, illegal, halted
  );
  modport slave (
    input instr_valid, instr, sreg,
    output instr_ready, opcode, operand_a, operand_b, alu_start, hold, jump_en, pc, illegal, halted
  );
endinterface

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle FETCH/EXEC/MUL_WAIT/HALT control unit owning the pc
module control_unit_mc #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int INSTR_W = 32,
  parameter int ADDR_W = 9,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst_n,
  control_unit_mc_if.slave bus
);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam int TW = (2 * DATA_W > ADDR_W) ? 2 * DATA_W : ADDR_W;
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(5'h00);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'h01);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'h02);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5'h03);
  localparam logic [OP_W-1:0] OP_OR = OP_W'(5'h04);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(5'h0B);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(5'h10);
  localparam logic [OP_W-1:0] OP_JZ = OP_W'(5'h11);
  localparam logic [OP_W-1:0] OP_JC = OP_W'(5'h12);
  localparam logic [OP_W-1:0] OP_JN = OP_W'(5'h13);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(5'h1F);
  typedef enum logic [1:0] {FETCH, EXEC, MUL_WAIT, HALT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] pc_nx, target;
  logic [TW-1:0] wide;
  logic [OP_W-1:0] op;
  logic is_alu, is_mul, is_jmp, legal, take, in_exec, stay;
  always_comb begin
    op = bus.opcode;
    is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    is_mul = op == OP_MUL;
    is_jmp = op inside {OP_JMP, OP_JZ, OP_JC, OP_JN};
    legal = is_alu || is_mul || is_jmp || op == OP_NOP || op == OP_HLT;
    take = op == OP_JMP || (op == OP_JZ && bus.sreg[0]) || (op == OP_JC && bus.sreg[1]) || (op == OP_JN && bus.sreg[2]);
    wide = TW'({bus.operand_b, bus.operand_a});
    target = wide[ADDR_W-1:0];
    in_exec = state == EXEC;
    stay = op == OP_HLT || (is_mul && MUL_LAT > 1);
    bus.instr_ready = state == FETCH;
    bus.alu_start = in_exec && (is_alu || is_mul);
    bus.hold = (in_exec && is_mul) || state == MUL_WAIT;
    bus.jump_en = in_exec && take;
    bus.illegal = in_exec && !legal;
    bus.halted = state == HALT;
    state_nx = state;
    cnt_nx = cnt;
    pc_nx = bus.pc;
    case (state)
      FETCH: state_nx = bus.instr_valid ? EXEC : FETCH;
      EXEC: begin
        state_nx = op == OP_HLT ? HALT : (is_mul && MUL_LAT > 1) ? MUL_WAIT : FETCH;
        pc_nx = stay ? bus.pc : take ? target : bus.pc + 1'b1;
        cnt_nx = CW'(MUL_LAT - 1);
      end
      MUL_WAIT: begin
        cnt_nx = cnt - 1'b1;
        state_nx = cnt == CW'(1) ? FETCH : MUL_WAIT;
        pc_nx = cnt == CW'(1) ? bus.pc + 1'b1 : bus.pc;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt <= '0;
      bus.pc <= '0;
      bus.opcode <= '0;
      bus.operand_a <= '0;
      bus.operand_b <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.pc <= pc_nx;
      if (bus.instr_ready && bus.instr_valid) begin
        bus.opcode <= bus.instr[2*DATA_W+OP_W-1:2*DATA_W];
        bus.operand_a <= bus.instr[DATA_W-1:0];
        bus.operand_b <= bus.instr[2*DATA_W-1:DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: directed self-checking bench for control_unit_mc
module tb_control_unit_mc;
  logic clk = 0;
  logic rst_n = 0;
  int n_cmp = 0;
  int n_err = 0;
  control_unit_mc_if bus ();
  control_unit_mc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] w);
    bus.instr = w;
    bus.instr_valid = 1;
    tick();
    bus.instr_valid = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    n_cmp++; if (bus.pc !== 9'h000) begin n_err++; $display("FAIL reset_pc: got %h want 000", bus.pc); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    n_cmp++; if ({bus.alu_start, bus.hold, bus.jump_en, bus.illegal, bus.halted} !== 5'b0) begin n_err++; $display("FAIL reset_pulses: got %b want 00000", {bus.alu_start, bus.hold, bus.jump_en, bus.illegal, bus.halted}); end
    n_cmp++; if ({bus.opcode, bus.operand_b, bus.operand_a} !== 21'h0) begin n_err++; $display("FAIL reset_fields: got %h want 0", {bus.opcode, bus.operand_b, bus.operand_a}); end
    rst_n = 1;
  endtask
  task automatic test_add();
    issue(32'h00010503);
    n_cmp++; if (bus.opcode !== 5'h01) begin n_err++; $display("FAIL add_opcode: got %h want 01", bus.opcode); end
    n_cmp++; if (bus.operand_a !== 8'h03) begin n_err++; $display("FAIL add_opa: got %h want 03", bus.operand_a); end
    n_cmp++; if (bus.operand_b !== 8'h05) begin n_err++; $display("FAIL add_opb: got %h want 05", bus.operand_b); end
    n_cmp++; if ({bus.alu_start, bus.instr_ready, bus.hold} !== 3'b100) begin n_err++; $display("FAIL add_exec_ctl: got %b want 100", {bus.alu_start, bus.instr_ready, bus.hold}); end
    tick();
    n_cmp++; if (bus.pc !== 9'h001) begin n_err++; $display("FAIL add_pc: got %h want 001", bus.pc); end
    n_cmp++; if ({bus.alu_start, bus.instr_ready} !== 2'b01) begin n_err++; $display("FAIL add_fetch_ctl: got %b want 01", {bus.alu_start, bus.instr_ready}); end
  endtask
  task automatic test_multiply();
    issue(32'h000B0202);
    n_cmp++; if ({bus.alu_start, bus.hold, bus.instr_ready} !== 3'b110) begin n_err++; $display("FAIL mul_exec: got %b want 110", {bus.alu_start, bus.hold, bus.instr_ready}); end
    bus.instr = 32'h00010101;
    bus.instr_valid = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++; if ({bus.alu_start, bus.hold, bus.instr_ready} !== 3'b010) begin n_err++; $display("FAIL mul_wait%0d: got %b want 010", i, {bus.alu_start, bus.hold, bus.instr_ready}); end
      n_cmp++; if (bus.pc !== 9'h001 || bus.opcode !== 5'h0B) begin n_err++; $display("FAIL mul_wait%0d_state: got pc=%h op=%h want pc=001 op=0b", i, bus.pc, bus.opcode); end
    end
    tick();
    n_cmp++; if ({bus.hold, bus.instr_ready} !== 2'b01 || bus.pc !== 9'h002) begin n_err++; $display("FAIL mul_done: got hold/ready=%b pc=%h want 01 pc=002", {bus.hold, bus.instr_ready}, bus.pc); end
    n_cmp++; if (bus.opcode !== 5'h0B) begin n_err++; $display("FAIL mul_not_accepted: got op=%h want 0b", bus.opcode); end
    tick();
    bus.instr_valid = 0;
    n_cmp++; if (bus.opcode !== 5'h01 || bus.operand_a !== 8'h01 || bus.alu_start !== 1'b1) begin n_err++; $display("FAIL mul_next_accept: got op=%h a=%h start=%b want 01 01 1", bus.opcode, bus.operand_a, bus.alu_start); end
    tick();
    n_cmp++; if (bus.pc !== 9'h003) begin n_err++; $display("FAIL mul_next_pc: got %h want 003", bus.pc); end
  endtask
  task automatic test_jumps();
    bus.sreg = 4'b0001;
    issue(32'h00110045);
    n_cmp++; if (bus.jump_en !== 1'b1) begin n_err++; $display("FAIL jz_taken_pulse: got %b want 1", bus.jump_en); end
    tick();
    n_cmp++; if (bus.pc !== 9'h045 || bus.jump_en !== 1'b0) begin n_err++; $display("FAIL jz_taken_pc: got pc=%h je=%b want 045 0", bus.pc, bus.jump_en); end
    bus.sreg = 4'b0000;
    issue(32'h00110045);
    n_cmp++; if (bus.jump_en !== 1'b0) begin n_err++; $display("FAIL jz_not_taken_pulse: got %b want 0", bus.jump_en); end
    tick();
    n_cmp++; if (bus.pc !== 9'h046) begin n_err++; $display("FAIL jz_not_taken_pc: got %h want 046", bus.pc); end
    bus.sreg = 4'b0100;
    issue(32'h001300AB);
    n_cmp++; if (bus.jump_en !== 1'b1) begin n_err++; $display("FAIL jn_taken_pulse: got %b want 1", bus.jump_en); end
    tick();
    n_cmp++; if (bus.pc !== 9'h0AB) begin n_err++; $display("FAIL jn_taken_pc: got %h want 0ab", bus.pc); end
    issue(32'h00120010);
    n_cmp++; if (bus.jump_en !== 1'b0) begin n_err++; $display("FAIL jc_not_taken_pulse: got %b want 0", bus.jump_en); end
    tick();
    n_cmp++; if (bus.pc !== 9'h0AC) begin n_err++; $display("FAIL jc_not_taken_pc: got %h want 0ac", bus.pc); end
  endtask
  task automatic test_wrap();
    bus.sreg = 4'b0000;
    issue(32'h001001FF);
    n_cmp++; if (bus.jump_en !== 1'b1) begin n_err++; $display("FAIL jmp_pulse: got %b want 1", bus.jump_en); end
    tick();
    n_cmp++; if (bus.pc !== 9'h1FF) begin n_err++; $display("FAIL jmp_pc: got %h want 1ff", bus.pc); end
    issue(32'h00000000);
    n_cmp++; if ({bus.alu_start, bus.jump_en, bus.illegal} !== 3'b000) begin n_err++; $display("FAIL nop_exec: got %b want 000", {bus.alu_start, bus.jump_en, bus.illegal}); end
    tick();
    n_cmp++; if (bus.pc !== 9'h000) begin n_err++; $display("FAIL nop_wrap_pc: got %h want 000", bus.pc); end
  endtask
  task automatic test_illegal_halt();
    issue(32'h00070000);
    n_cmp++; if ({bus.illegal, bus.alu_start} !== 2'b10) begin n_err++; $display("FAIL illegal_pulse: got %b want 10", {bus.illegal, bus.alu_start}); end
    tick();
    n_cmp++; if (bus.illegal !== 1'b0 || bus.pc !== 9'h001 || bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL illegal_after: got ill=%b pc=%h rdy=%b want 0 001 1", bus.illegal, bus.pc, bus.instr_ready); end
    issue(32'h001F0000);
    tick();
    bus.instr = 32'h00010101;
    bus.instr_valid = 1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if ({bus.halted, bus.instr_ready, bus.alu_start, bus.hold} !== 4'b1000 || bus.pc !== 9'h001) begin n_err++; $display("FAIL halt_cycle%0d: got h/r/s/hd=%b pc=%h want 1000 001", i, {bus.halted, bus.instr_ready, bus.alu_start, bus.hold}, bus.pc); end
      tick();
    end
    bus.instr_valid = 0;
  endtask
  task automatic test_reset_recovery();
    rst_n = 0;
    tick();
    rst_n = 1;
    n_cmp++; if ({bus.halted, bus.instr_ready, bus.hold} !== 3'b010 || bus.pc !== 9'h000) begin n_err++; $display("FAIL halt_reset: got h/r/hd=%b pc=%h want 010 000", {bus.halted, bus.instr_ready, bus.hold}, bus.pc); end
    issue(32'h000B0303);
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    n_cmp++; if ({bus.hold, bus.instr_ready, bus.halted} !== 3'b010 || bus.pc !== 9'h000) begin n_err++; $display("FAIL mulwait_reset: got hd/r/h=%b pc=%h want 010 000", {bus.hold, bus.instr_ready, bus.halted}, bus.pc); end
    n_cmp++; if (bus.opcode !== 5'h00) begin n_err++; $display("FAIL mulwait_reset_op: got %h want 00", bus.opcode); end
    issue(32'h000B0303);
    begin
      int h = 0;
      for (int i = 0; i < 5; i++) begin
        if (bus.hold === 1'b1) h++;
        tick();
      end
      n_cmp++; if (h != 3) begin n_err++; $display("FAIL mul_after_reset_hold: got %0d cycles want 3", h); end
    end
    n_cmp++; if (bus.pc !== 9'h001) begin n_err++; $display("FAIL mul_after_reset_pc: got %h want 001", bus.pc); end
  endtask
  initial begin
    bus.instr_valid = 0;
    bus.instr = '0;
    bus.sreg = '0;
    test_reset();
    test_add();
    test_multiply();
    test_jumps();
    test_wrap();
    test_illegal_halt();
    test_reset_recovery();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
